// File: rtl/soc_rtc_pkg.sv
// Shared definitions for the RTC peripheral: register map, CTRL bit positions
// and bus FSM encoding.
package soc_rtc_pkg;

  localparam logic [3:0] RTC_CTRL_OFS     = 4'h0;
  localparam logic [3:0] RTC_PRESCALE_OFS = 4'h4;
  localparam logic [3:0] RTC_SEC_OFS      = 4'h8;
  localparam logic [3:0] RTC_ALARM_OFS    = 4'hC;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_IRQ_EN_BIT  = 1;
  localparam int CTRL_ALARM_F_BIT = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } rtc_state_e;

endpackage

// File: rtl/rtc_prescaler.sv
// Programmable clock divider: emits a one-clock tick every prescale+1 enabled
// clocks; clr restarts the count.
module rtc_prescaler #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] prescale,
  output logic         tick
);

  logic [W-1:0] pcnt;

  assign tick = en && (pcnt == prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pcnt <= '0;
    else if (clr)   pcnt <= '0;
    else if (tick)  pcnt <= '0;
    else if (en)    pcnt <= pcnt + 1'b1;
  end

endmodule

// File: rtl/soc_rtc_peripheral.sv
// RTC slave on the arbiter: seconds counter with prescaler, sticky alarm flag
// and level irq, behind a two-state single-cycle-latency bus FSM.
module soc_rtc_peripheral
  import soc_rtc_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] PRESCALE_RST = 32'd99,
  parameter int                    DEC_BITS     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bus_sel,
  input  logic [DATA_WIDTH-1:0] bus_addr,
  input  logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_we,
  output logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  bus_ready,
  output logic                  irq
);

  rtc_state_e            state, next_state;
  logic                  ctrl_en, ctrl_irq_en, alarm_f;
  logic [DATA_WIDTH-1:0] prescale_q, sec_q, alarm_q, rdata_q, rd_val;
  logic                  access, wr, rd, hi_set, mapped;
  logic [1:0]            reg_idx;
  logic                  wr_ctrl, wr_presc, wr_sec, wr_alarm;
  logic                  tick, alarm_hit, alarm_f_nxt, irq_en_nxt, irq_q;
  logic [DATA_WIDTH-1:0] sec_inc;
  logic                  addr_unused;

  // Offsets between 0x10 and the decode limit are reserved.
  if (DEC_BITS > 4) begin : g_hi
    assign hi_set = |bus_addr[DEC_BITS-1:4];
  end else begin : g_nohi
    assign hi_set = 1'b0;
  end
  assign addr_unused = ^{bus_addr[DATA_WIDTH-1:DEC_BITS], bus_addr[1:0]};

  assign reg_idx  = bus_addr[3:2];
  assign mapped   = !hi_set;
  assign access   = (state == ST_IDLE) && bus_sel;
  assign wr       = access && bus_we;
  assign rd       = access && !bus_we;
  assign wr_ctrl  = wr && mapped && (reg_idx == RTC_CTRL_OFS[3:2]);
  assign wr_presc = wr && mapped && (reg_idx == RTC_PRESCALE_OFS[3:2]);
  assign wr_sec   = wr && mapped && (reg_idx == RTC_SEC_OFS[3:2]);
  assign wr_alarm = wr && mapped && (reg_idx == RTC_ALARM_OFS[3:2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (bus_sel) next_state = ST_RESP;
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  assign bus_ready = (state == ST_RESP);

  // A SEC write also restarts the prescaler so the new second is full length.
  rtc_prescaler #(.W(DATA_WIDTH)) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (ctrl_en),
    .clr      (wr_presc || wr_sec),
    .prescale (prescale_q),
    .tick     (tick)
  );

  // Compare against the pre-edge ALARM; a SEC write overrides the tick.
  assign sec_inc     = sec_q + 1'b1;
  assign alarm_hit   = tick && !wr_sec && (sec_inc == alarm_q);
  assign alarm_f_nxt = alarm_hit || (alarm_f && !(wr_ctrl && bus_wdata[CTRL_ALARM_F_BIT]));
  assign irq_en_nxt  = wr_ctrl ? bus_wdata[CTRL_IRQ_EN_BIT] : ctrl_irq_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      alarm_f     <= 1'b0;
      irq_q       <= 1'b0;
      prescale_q  <= PRESCALE_RST;
      sec_q       <= '0;
      alarm_q     <= '1;
    end else begin
      if (wr_ctrl) ctrl_en <= bus_wdata[CTRL_EN_BIT];
      ctrl_irq_en <= irq_en_nxt;
      alarm_f     <= alarm_f_nxt;
      irq_q       <= alarm_f_nxt && irq_en_nxt;
      if (wr_presc) prescale_q <= bus_wdata;
      if (wr_alarm) alarm_q <= bus_wdata;
      if (wr_sec)    sec_q <= bus_wdata;
      else if (tick) sec_q <= sec_inc;
    end
  end

  assign irq = irq_q;

  always_comb begin
    rd_val = '0;
    if (mapped) begin
      case (reg_idx)
        RTC_CTRL_OFS[3:2]: begin
          rd_val[CTRL_EN_BIT]      = ctrl_en;
          rd_val[CTRL_IRQ_EN_BIT]  = ctrl_irq_en;
          rd_val[CTRL_ALARM_F_BIT] = alarm_f;
        end
        RTC_PRESCALE_OFS[3:2]: rd_val = prescale_q;
        RTC_SEC_OFS[3:2]:      rd_val = sec_q;
        default:               rd_val = alarm_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_q <= '0;
    else if (rd) rdata_q <= rd_val;
  end

  assign bus_rdata = rdata_q;

endmodule
